proj_fm_reader: RTL and testbench

//  Read-side sequencer for one FM buffer; the counterpart of the FM write-index counter.

---
 rtl/proj_pkg.sv | 7 +
 rtl/proj_fm_reader_if.sv | 26 ++
 rtl/proj_skid_fifo.sv | 59 +++++
 rtl/proj_fm_reader.sv | 108 ++++++++++
 tb/tb_proj_fm_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - FM buffer geometry and reader state type shared by the FM reader files
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 8;
  localparam int FM_DATA_W      = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fm_rd_state_t;
endpackage

// File: rtl/proj_fm_reader_if.sv
// rtl/proj_fm_reader_if.sv - buffer read port, output stream and status of the FM reader
interface proj_fm_reader_if #(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int DATA_W         = proj_pkg::FM_DATA_W
);
  logic                      start;
  logic                      rd_en;
  logic [FM_BUFFER_SIZE-1:0] rd_index;
  logic [DATA_W-1:0]         rd_data;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, rd_data, out_ready,
    output rd_en, rd_index, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, rd_data, out_ready,
    input  rd_en, rd_index, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/proj_skid_fifo.sv
// rtl/proj_skid_fifo.sv - 2-entry output FIFO; head entry only moves on pop or push-into-empty
module proj_skid_fifo import proj_pkg::*; #(
  parameter int W = FM_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    case ({push, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) e0_d = din;
        else                 e1_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign dout  = e0_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;
endmodule

// File: rtl/proj_fm_reader.sv
// rtl/proj_fm_reader.sv - read-side sequencer streaming one FM buffer downstream
// Optional PROJ_FM_READER_PENDING_EN: queue one start that arrives while a pass is running.
module proj_fm_reader import proj_pkg::*; #(
  parameter int FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
  parameter int DATA_W         = proj_pkg::FM_DATA_W
) (
  input logic               in_clk,
  input logic               in_rst,
  proj_fm_reader_if.master  bus
);
  localparam logic [FM_BUFFER_SIZE-1:0] LAST_IDX = FM_BUFFER_SIZE'(FM_BUFFER_SIZE - 1);
  localparam logic [FM_BUFFER_SIZE-1:0] IDX_ONE  = FM_BUFFER_SIZE'(1);

  fm_rd_state_t              state_q, state_d;
  logic [FM_BUFFER_SIZE-1:0] idx_q, idx_d;
  logic                      inflight_q, inflight_d;
  logic                      last_tag_q, last_tag_d;
  logic [1:0]                fifo_count;
  logic                      fifo_valid;
  logic [DATA_W:0]           fifo_dout;
  logic                      pop, rd_en, issue_last, drained, restart;
  logic [2:0]                occupancy;

  // A word leaving this cycle frees its slot, which keeps 1 word/cycle with only 2 entries.
  assign pop        = fifo_valid && bus.out_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en      = (state_q == FETCH) && (occupancy < 3'd2);
  assign issue_last = rd_en && (idx_q == LAST_IDX);
  assign drained    = (state_q == DRAIN) && (fifo_count == 2'd0) && !inflight_q;

`ifdef PROJ_FM_READER_PENDING_EN
  logic pending_q, pending_d;

  assign restart = pending_q || (bus.start && (state_q != IDLE));

  always_comb begin
    pending_d = pending_q;
    if (drained && restart)                    pending_d = 1'b0;
    else if (bus.start && (state_q != IDLE))   pending_d = 1'b1;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inflight_d = rd_en;
    last_tag_d = issue_last;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (rd_en)      idx_d   = idx_q + IDX_ONE;
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drained) begin
          state_d = restart ? FETCH : IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      last_tag_q <= last_tag_d;
    end
  end

  proj_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (in_clk),
    .rst   (in_rst),
    .push  (inflight_q),
    .din   ({last_tag_q, bus.rd_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_index  = rd_en ? idx_q : '0;
  assign bus.out_data  = fifo_dout[DATA_W-1:0];
  assign bus.out_valid = fifo_valid;
  assign bus.out_last  = fifo_valid && fifo_dout[DATA_W];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = drained;
endmodule

// File: tb/tb_proj_fm_reader.sv
// tb/tb_proj_fm_reader.sv - directed self-checking bench for proj_fm_reader
`timescale 1ns/1ps
module tb_proj_fm_reader;
  import proj_pkg::*;

  localparam int N = 8;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proj_fm_reader_if #(.FM_BUFFER_SIZE(N), .DATA_W(W)) bus ();
  proj_fm_reader_if #(.FM_BUFFER_SIZE(1), .DATA_W(W)) bus1 ();

  proj_fm_reader #(.FM_BUFFER_SIZE(N), .DATA_W(W)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  proj_fm_reader #(.FM_BUFFER_SIZE(1), .DATA_W(W)) dut1 (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus1)
  );

  function automatic logic [31:0] mem_word(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  localparam logic [31:0] MEM1_WORD = 32'h5EED_0001;

  // Buffer memory: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en)  bus.rd_data  <= mem_word(int'(bus.rd_index));
    if (bus1.rd_en) bus1.rd_data <= MEM1_WORD;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int n_rd, n_xfer, n_done, n_bad_order, n_bad_stable, max_out, n_busy_gap, n_extra, n_held_bad, rd_at_stall;

  // Starts a pass at the current negedge and tracks it until target_done done pulses.
  // pattern 0: out_ready low for cycles 1..stall then high; pattern 1: 1,0,0,1 repeating.
  task automatic watch(input int pattern, input int stall, input int target_done,
                       input bit poke, input int max_cyc);
    logic [W-1:0] prev_data;
    logic         prev_last, prev_stall;
    n_rd = 0; n_xfer = 0; n_done = 0; n_bad_order = 0; n_bad_stable = 0;
    max_out = 0; n_busy_gap = 0; n_extra = 0; n_held_bad = 0; rd_at_stall = 0;
    prev_data = '0; prev_last = 1'b0; prev_stall = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= max_cyc && n_done < target_done; c++) begin
      @(negedge clk);
      bus.start = poke && (c == 6);
      if (pattern == 1) bus.out_ready = (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
      else              bus.out_ready = (c > stall);
      #1;
      if (bus.rd_en) begin
        if (int'(bus.rd_index) != (n_rd % N)) n_bad_order++;
        n_rd++;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        n_bad_stable++;
      if (c >= 3 && c <= stall && (!bus.out_valid || bus.out_data !== mem_word(0)))
        n_held_bad++;
      if (c == stall) rd_at_stall = n_rd;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data !== mem_word(n_xfer % N) || bus.out_last !== ((n_xfer % N) == N - 1))
          n_bad_order++;
        n_xfer++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (n_rd - n_xfer > max_out) max_out = n_rd - n_xfer;
      if (!bus.busy) n_busy_gap++;
      if (bus.done) begin
        n_done++;
        if (n_xfer != n_done * N) n_bad_order++;
        if (poke && n_done == 1) bus.start = 1'b1;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.rd_en || bus.busy || bus.done || bus.out_valid) n_extra++;
    end
  endtask

  task automatic check_pass(input string tag, input int passes);
    check({tag, "_reads"}, n_rd, passes * N);
    check({tag, "_xfers"}, n_xfer, passes * N);
    check({tag, "_done_count"}, n_done, passes);
    check({tag, "_order"}, n_bad_order, 0);
    check({tag, "_stable"}, n_bad_stable, 0);
    check({tag, "_no_overflow"}, max_out <= 2, 1'b1);
    check({tag, "_busy_gap"}, n_busy_gap, 0);
    check({tag, "_idle_after"}, n_extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;  bus.out_ready = 1'b0;
    bus1.start = 1'b0; bus1.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_rd_index", bus.rd_index, 0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst1_busy", bus1.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: free-running stream, cycle-exact
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("t1_rd_en", bus.rd_en, (c <= 8));
      if (c <= 8) check("t1_rd_index", bus.rd_index, c - 1);
      check("t1_valid", bus.out_valid, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) check("t1_data", bus.out_data, mem_word(c - 3));
      check("t1_last", bus.out_last, (c == 10));
      check("t1_done", bus.done, (c == 11));
      check("t1_busy", bus.busy, (c <= 11));
    end
    @(negedge clk);

    // 2: ready pattern 1,0,0,1
    watch(1, 0, 1, 1'b0, 80);
    check_pass("t2", 1);

    // 3: long stall after start
    watch(0, 20, 1, 1'b0, 80);
    check_pass("t3", 1);
    check("t3_reads_during_stall", rd_at_stall, 2);
    check("t3_held_word0", n_held_bad, 0);

    // 4: reset mid-pass
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    #1;
    check("t4_rd_en", bus.rd_en, 1'b0);
    check("t4_rd_index", bus.rd_index, 0);
    check("t4_out_valid", bus.out_valid, 1'b0);
    check("t4_out_last", bus.out_last, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_done", bus.done, 1'b0);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.busy) n_done++;
    end
    check("t4_quiet_after_reset", n_done, 0);
    @(negedge clk);
    watch(0, 0, 1, 1'b0, 40);
    check_pass("t4_fresh", 1);

    // 5: starts while busy
    @(negedge clk);
`ifdef PROJ_FM_READER_PENDING_EN
    watch(0, 0, 2, 1'b1, 80);
    check_pass("t5_pending", 2);
`else
    watch(0, 0, 1, 1'b1, 80);
    check_pass("t5_ignored", 1);
`endif

    // 6: single-entry buffer
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      #1;
      check("t6_rd_en", bus1.rd_en, (c == 1));
      check("t6_rd_index", bus1.rd_index, 0);
      check("t6_valid", bus1.out_valid, (c == 3));
      if (c == 3) check("t6_data", bus1.out_data, MEM1_WORD);
      check("t6_last", bus1.out_last, (c == 3));
      check("t6_done", bus1.done, (c == 4));
      check("t6_busy", bus1.busy, (c <= 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
